// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: FSM state codes,
// processor mode encodings and the completed-packet counter width.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Plain-vector aliases of the state codes for legacy state registers
    localparam logic [0:0] ST_IDLE = ARB_IDLE;
    localparam logic [0:0] ST_BUSY = ARB_BUSY;

    localparam logic [1:0] MODE_PASS      = 2'd0;
    localparam logic [1:0] MODE_BYTE_REV  = 2'd1;
    localparam logic [1:0] MODE_ADD_CONST = 2'd2;

    localparam int PKT_CNT_W = 16;

    function automatic logic [PKT_CNT_W-1:0] pkt_count_next(input logic [PKT_CNT_W-1:0] cnt);
        return cnt + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request found scanning
// last+1, last+2, ... modulo NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int GW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [GW-1:0]      sel,
    output logic               any
);

    int idx_s;

    // Walk the offsets from farthest to nearest so the nearest hit wins
    always_comb begin
        sel   = {GW{1'b0}};
        any   = 1'b0;
        idx_s = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx_s = (int'(last) + k) % NUM_SRC;
            sel   = req[idx_s] ? GW'(idx_s) : sel;
            any   = any | req[idx_s];
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one stream processor between
// NUM_SRC AXI-Stream sources; the winner's mode/constant are held per packet.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int   TDATA_WIDTH = 32,
    parameter int   NUM_SRC     = 4,
    localparam int  GW          = $clog2(NUM_SRC)
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_SRC*TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                 s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                 s_axis_tlast,
    output logic [NUM_SRC-1:0]                 s_axis_tready,
    input  logic [2*NUM_SRC-1:0]               src_mode,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0]     src_constant,
    output logic [TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic [1:0]                         mode,
    output logic [TDATA_WIDTH-1:0]             constant_value,
    output logic [GW-1:0]                      grant_id,
    output logic                               busy,
    output logic [15:0]                        pkt_count
);

    localparam int KW = TDATA_WIDTH / 8;

    logic [0:0]             state_r;
    logic [GW-1:0]          grant_r;
    logic [GW-1:0]          last_grant_r;
    logic [1:0]             mode_r;
    logic [TDATA_WIDTH-1:0] const_r;
    logic [PKT_CNT_W-1:0]   pkt_count_r;

    logic [GW-1:0]          pick_sel_s;
    logic                   pick_any_s;
    logic [TDATA_WIDTH-1:0] fwd_tdata_s;
    logic [KW-1:0]          fwd_tkeep_s;
    logic                   fwd_tvalid_s;
    logic                   fwd_tlast_s;
    logic [NUM_SRC-1:0]     fwd_tready_s;
    logic                   pkt_end_s;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .GW      (GW)
    ) u_rr_pick (
        .req  (s_axis_tvalid),
        .last (last_grant_r),
        .sel  (pick_sel_s),
        .any  (pick_any_s)
    );

    // Zero-latency pass-through of the granted source; everything is closed in IDLE
    always_comb begin
        fwd_tdata_s  = {TDATA_WIDTH{1'b0}};
        fwd_tkeep_s  = {KW{1'b0}};
        fwd_tvalid_s = 1'b0;
        fwd_tlast_s  = 1'b0;
        fwd_tready_s = {NUM_SRC{1'b0}};
        if (state_r == ST_BUSY) begin
            fwd_tdata_s           = s_axis_tdata[grant_r*TDATA_WIDTH +: TDATA_WIDTH];
            fwd_tkeep_s           = s_axis_tkeep[grant_r*KW +: KW];
            fwd_tvalid_s          = s_axis_tvalid[grant_r];
            fwd_tlast_s           = s_axis_tlast[grant_r];
            fwd_tready_s[grant_r] = m_axis_tready;
        end else begin
            fwd_tready_s = {NUM_SRC{1'b0}};
        end
    end

    assign pkt_end_s = (state_r == ST_BUSY) & fwd_tvalid_s & m_axis_tready & fwd_tlast_s;

    // Arbitration in IDLE, grant lock until the tlast handshake in BUSY
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r      <= ST_IDLE;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NUM_SRC - 1);
            mode_r       <= MODE_PASS;
            const_r      <= {TDATA_WIDTH{1'b0}};
            pkt_count_r  <= {PKT_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        grant_r <= pick_sel_s;
                        mode_r  <= src_mode[pick_sel_s*2 +: 2];
                        const_r <= src_constant[pick_sel_s*TDATA_WIDTH +: TDATA_WIDTH];
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (pkt_end_s) begin
                        last_grant_r <= grant_r;
                        pkt_count_r  <= pkt_count_next(pkt_count_r);
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata   = fwd_tdata_s;
    assign m_axis_tkeep   = fwd_tkeep_s;
    assign m_axis_tvalid  = fwd_tvalid_s;
    assign m_axis_tlast   = fwd_tlast_s;
    assign s_axis_tready  = fwd_tready_s;
    assign mode           = mode_r;
    assign constant_value = const_r;
    assign grant_id       = grant_r;
    assign busy           = (state_r == ST_BUSY);
    assign pkt_count      = pkt_count_r;

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
Shares one axi_stream_processor between NUM_SRC AXI-Stream sources. Arbitration is round-robin at packet granularity. The granted source's mode and constant are latched and driven to the processor for the whole packet. The block sits directly upstream of the processor; its m_axis_* and config outputs connect 1:1 to the processor's s_axis_*, mode and constant_value.

Parameters:
TDATA_WIDTH, 32, data width per source; multiple of 8
NUM_SRC, 4, number of requesters; 2..8
GW, $clog2(NUM_SRC), grant index width (derived localparam)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous reset, active-high
s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  source i at bits [i*TDATA_WIDTH +: TDATA_WIDTH]
s_axis_tkeep  in  NUM_SRC*TDATA_WIDTH/8  packed per source, same scheme
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tlast  in  NUM_SRC  per-source last
s_axis_tready  out  NUM_SRC  per-source ready
src_mode  in  2*NUM_SRC  per-source processor mode, [i*2 +: 2]
src_constant  in  NUM_SRC*TDATA_WIDTH  per-source add constant
m_axis_tdata  out  TDATA_WIDTH  to processor
m_axis_tkeep  out  TDATA_WIDTH/8  to processor
m_axis_tvalid  out  1  to processor
m_axis_tlast  out  1  to processor
m_axis_tready  in  1  from processor
mode  out  2  latched mode of granted source
constant_value  out  TDATA_WIDTH  latched constant of granted source
grant_id  out  GW  index of current/last granted source
busy  out  1  high in BUSY state
pkt_count  out  16  completed packets, wraps at 0xFFFF->0

Behaviour:
- Reset (areset=1 at a clock edge): state=IDLE, s_axis_tready=0, m_axis_tvalid=0, mode=0, constant_value=0, grant_id=0, busy=0, pkt_count=0, last_grant=NUM_SRC-1, so source 0 has first priority. Reset mid-packet drops the packet. Sources must restart it; no recovery is attempted.
- FSM states IDLE and BUSY.
- IDLE: m_axis_tvalid=0, all s_axis_tready=0. If any s_axis_tvalid is high, select the first valid source scanning last_grant+1, last_grant+2, ... modulo NUM_SRC. Register grant_id=sel, mode=src_mode[sel], constant_value=src_constant[sel]. Go to BUSY next cycle. If no source is valid, stay in IDLE.
- BUSY: combinational forwarding from source grant_id:
  - m_axis_tdata, m_axis_tkeep, m_axis_tlast and m_axis_tvalid come from that source.
  - s_axis_tready[grant_id] = m_axis_tready; all other tready = 0.
  - Zero added latency.
- Packet end: a cycle in BUSY with m_axis_tvalid & m_axis_tready & m_axis_tlast. Next cycle: last_grant=grant_id, pkt_count+1, state=IDLE.
- One idle bubble cycle between packets is required. Arbitration latency is 1 cycle from IDLE with a valid request to the first m_axis_tvalid.
- Grant lock: no re-arbitration while BUSY. Other sources' valids are ignored until tlast completes. The granted source may drop tvalid mid-packet; the grant holds.
- mode and constant_value are stable for the whole packet. Changes on src_mode or src_constant while BUSY take effect only at the next grant.
- Backpressure: with m_axis_tready=0, the granted source sees tready=0. Data and valid pass through unchanged. No beat is lost or duplicated.
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,...,NUM_SRC-1,0. Each source waits at most NUM_SRC-1 packets.
- grant_id holds its value in IDLE until the next grant.
- Single-beat packets (tlast on the first beat) are legal.

Decomposition:
- Shared package axis_arb_pkg holds the FSM state enum (IDLE, BUSY), the mode encoding constants (PASS=0, BYTE_REV=1, ADD_CONST=2), and the pkt_count width constant.
- One sub-module, rr_pick:
  - Combinational round-robin priority selector.
  - Inputs: req[NUM_SRC], last[GW].
  - Outputs: sel[GW], any.
  - It is unit-tested separately.

Test Plan:
1. Source 0 only, mode=0, sends 2-beat packet 0xDEADBEEF/0xCAFEF00D, tkeep=F, m_axis_tready=1 -> m_axis_tvalid first high 1 cycle after request. Beats match in order, tlast on beat 2, grant_id=0, pkt_count=1.
2. Sources 0–3 each hold a 1-beat packet valid simultaneously, from reset -> grants 0,1,2,3,0 in order, one idle cycle between packets, pkt_count increments per packet.
3. Source 1 granted for a 4-beat packet; source 0 raises valid at beat 2 -> source 0 tready stays 0 until source 1's tlast handshake. Source 0 is granted next.
4. Source 2 granted with src_mode=2, constant=0x0A; src_mode[2] changed to 1 mid-packet -> mode output stays 2 for the whole packet and becomes 1 at source 2's next grant.
5. Backpressure: m_axis_tready=0 for 3 cycles mid-packet (data 0x12345678) -> s_axis_tready[grant]=0 during the stall. Output data holds stable; exactly one output handshake per input beat after release.
6. areset asserted during beat 2 of a 3-beat packet -> next cycle all outputs at reset values and state IDLE. After deassert, source 0 wins arbitration first.
